// File: rtl/gate_truth_checker.sv
// Self-test sequencer for a 2-input gate: walks {a,b} through 00,01,10,11, samples dut_y, compares with a truth table.
// Latency: done pulses 4*SETTLE_CYCLES+1 cycles after start is accepted; busy is high for 4*SETTLE_CYCLES cycles.
// Backpressure: none; start is honoured only in IDLE and is not queued while a run is in progress.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, expected     run request and 4-bit expected truth table (bit index = {a,b}), latched on accepted start
//   tt_a, tt_b, dut_y   stimulus driven to the gate under test and its returned output
//   busy, done, pass    run in progress, one-cycle completion pulse, all-combinations-matched flag
//   observed, fail_mask captured dut_y per combination and per-combination mismatch bits
module gate_truth_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected,
    output logic       tt_a,
    output logic       tt_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] observed,
    output logic [3:0] fail_mask
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [3:0]    exp_lat;
    logic [3:0]    mask_nxt;
    logic          accept;
    logic          capture;

    // State, combination index and settle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        capture   = 1'b0;
        // Mismatch vector as it will look once the current combination is captured;
        // used both for the fail_mask update and for pass on the final capture.
        mask_nxt      = fail_mask;
        mask_nxt[idx] = dut_y ^ exp_lat[idx];
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                    idx_nxt   = 2'd0;
                    cnt_nxt   = '0;
                end
            end
            DRIVE: begin
                if (cnt == CNT_LAST) begin
                    capture = 1'b1;
                    cnt_nxt = '0;
                    if (idx == 2'd3) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs: decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_a      <= 1'b0;
            tt_b      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            observed  <= 4'd0;
            fail_mask <= 4'd0;
            exp_lat   <= 4'd0;
        end else begin
            busy <= (state_nxt == DRIVE);
            tt_a <= (state_nxt == DRIVE) && idx_nxt[1];
            tt_b <= (state_nxt == DRIVE) && idx_nxt[0];
            done <= (state_nxt == DONE);
            if (accept) begin
                exp_lat   <= expected;
                observed  <= 4'd0;
                fail_mask <= 4'd0;
                pass      <= 1'b0;
            end
            if (capture) begin
                observed[idx] <= dut_y;
                fail_mask     <= mask_nxt;
                if (idx == 2'd3) begin
                    pass <= (mask_nxt == 4'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Testbench for gate_truth_checker: table-driven runs against a modelled gate with a result scoreboard,
// plus hand-written sequences for reset mid-run, held start and settle-glitch filtering.
// Two instances: SETTLE_CYCLES=2 (main) and SETTLE_CYCLES=3 (glitch filtering).
module tb_gate_truth_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // SETTLE_CYCLES = 2 instance; gate model is an OR gate or a stuck-at-0 output.
    logic       start2;
    logic [3:0] exp2;
    logic       tt_a2, tt_b2, y2, busy2, done2, pass2;
    logic [3:0] obs2, fm2;
    logic       mode2;
    assign y2 = mode2 ? 1'b0 : (tt_a2 | tt_b2);

    // SETTLE_CYCLES = 3 instance; OR gate with an injectable glitch.
    logic       start3;
    logic [3:0] exp3;
    logic       tt_a3, tt_b3, y3, busy3, done3, pass3;
    logic [3:0] obs3, fm3;
    logic       glitch3;
    assign y3 = (tt_a3 | tt_b3) ^ glitch3;

    gate_truth_checker #(.SETTLE_CYCLES(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .expected(exp2),
        .tt_a(tt_a2), .tt_b(tt_b2), .dut_y(y2),
        .busy(busy2), .done(done2), .pass(pass2),
        .observed(obs2), .fail_mask(fm2)
    );

    gate_truth_checker #(.SETTLE_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .expected(exp3),
        .tt_a(tt_a3), .tt_b(tt_b3), .dut_y(y3),
        .busy(busy3), .done(done3), .pass(pass3),
        .observed(obs3), .fail_mask(fm3)
    );

    typedef struct {
        logic       mode;
        logic [3:0] expected;
        logic [3:0] observed;
        logic [3:0] fail_mask;
        logic       pass;
    } vec_t;

    vec_t tbl[3];
    vec_t fail0;
    vec_t sb[$];

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, req, req);
    endtask

    task automatic pop_check(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_nonempty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_observed"},  int'(obs2), int'(e.observed));
        chk({tag, "_fail_mask"}, int'(fm2),  int'(e.fail_mask));
        chk({tag, "_pass"},      int'(pass2), int'(e.pass));
    endtask

    // Called at a negedge; start is sampled at the following posedge (edge 0).
    task automatic run2(input vec_t v, input string tag);
        logic [15:0] seq;
        int bcnt;
        int done_at;
        seq     = '0;
        bcnt    = 0;
        done_at = 0;
        mode2   = v.mode;
        exp2    = v.expected;
        sb.push_back(v);
        start2  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (busy2) begin
                seq = {seq[13:0], tt_a2, tt_b2};
                bcnt++;
            end
            if (done2) begin
                done_at = k;
                break;
            end
        end
        chk({tag, "_done_edge"}, done_at, 9);
        chk({tag, "_busy_cycles"}, bcnt, 8);
        chk({tag, "_ab_sequence"}, int'(seq), int'(16'b00_00_01_01_10_10_11_11));
        if (done_at != 0) begin
            chk({tag, "_busy_at_done"}, int'(busy2), 0);
            pop_check(tag);
            @(negedge clk);
            chk({tag, "_done_one_cycle"}, int'(done2), 0);
            chk({tag, "_pass_held"}, int'(pass2), int'(v.pass));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] outs;
        int nd, d1, d2, done_at, ng;
        logic pbusy;
        logic [1:0] ptt;

        tbl[0] = '{mode: 1'b0, expected: 4'b1110, observed: 4'b1110, fail_mask: 4'b0000, pass: 1'b1};
        tbl[1] = '{mode: 1'b0, expected: 4'b1000, observed: 4'b1110, fail_mask: 4'b0110, pass: 1'b0};
        tbl[2] = '{mode: 1'b1, expected: 4'b1110, observed: 4'b0000, fail_mask: 4'b1110, pass: 1'b0};
        fail0  = '{mode: 1'b0, expected: 4'b0000, observed: 4'b1110, fail_mask: 4'b1110, pass: 1'b0};

        rst = 1'b1; start2 = 1'b0; start3 = 1'b0; exp2 = 4'd0; exp3 = 4'd0;
        mode2 = 1'b0; glitch3 = 1'b0;
        repeat (3) @(negedge clk);
        outs = {3'd0, tt_a2, tt_b2, busy2, done2, pass2, obs2, fm2};
        chk("reset_outputs_s2", int'(outs), 0);
        outs = {3'd0, tt_a3, tt_b3, busy3, done3, pass3, obs3, fm3};
        chk("reset_outputs_s3", int'(outs), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            run2(tbl[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Reset on the 5th DRIVE cycle aborts the run without a done pulse.
        mode2 = 1'b0; exp2 = 4'b1110; start2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start2 = 1'b0;
        end
        chk("rst_mid_busy_before", int'(busy2), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        outs = {3'd0, tt_a2, tt_b2, busy2, done2, pass2, obs2, fm2};
        chk("rst_mid_outputs_zero", int'(outs), 0);
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (done2) nd++;
        end
        chk("rst_mid_no_done", nd, 0);
        run2(tbl[0], "after_rst");
        @(negedge clk);

        // start held high for 25 cycles; expected changes during the first run.
        mode2 = 1'b0; exp2 = 4'b1110; start2 = 1'b1;
        sb.push_back(tbl[0]);
        nd = 0; d1 = 0; d2 = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 4) begin
                exp2 = 4'b0000;
                sb.push_back(fail0);
                sb.push_back(fail0);
            end
            if (done2) begin
                nd++;
                if (nd == 1) d1 = k;
                else if (nd == 2) d2 = k;
                pop_check($sformatf("hold_run%0d", nd));
            end
        end
        start2 = 1'b0;
        chk("hold_done_count", nd, 2);
        chk("hold_first_done_edge", d1, 9);
        chk("hold_done_spacing", d2 - d1, 10);
        // Third run was accepted before start dropped; drain it.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done2) pop_check("hold_run3");
        end
        chk("hold_scoreboard_drained", sb.size(), 0);

        // SETTLE_CYCLES=3: glitch dut_y during the first cycle of every combination.
        exp3 = 4'b1110; start3 = 1'b1;
        pbusy = 1'b0; ptt = 2'b00; ng = 0; done_at = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (busy3 && (!pbusy || {tt_a3, tt_b3} != ptt)) begin
                glitch3 = 1'b1;
                ng++;
            end else begin
                glitch3 = 1'b0;
            end
            pbusy = busy3;
            ptt   = {tt_a3, tt_b3};
            if (done3) begin
                done_at = k;
                break;
            end
        end
        glitch3 = 1'b0;
        chk("glitch_injected_count", ng, 4);
        chk("glitch_done_edge", done_at, 13);
        chk("glitch_pass", int'(pass3), 1);
        chk("glitch_observed", int'(obs3), int'(4'b1110));
        chk("glitch_fail_mask", int'(fm3), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
